// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bytes are taken on a valid/ready handshake; tx is registered and idles high.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line high, ready for a byte
// S_START  | start bit (low) for one bit time
// S_DATA   | data bits 0..7, LSB first
// S_PARITY | parity bit (even or odd mode only)
// S_STOP   | stop bit(s), high for STOP_BITS bit times
module uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY       = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t        state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          par_bit;
   logic          bit_end;

   assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         clk_cnt  <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         tx       <= 1'b1;
         tx_ready <= 1'b0;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               tx       <= 1'b1;
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
               if (tx_valid && tx_ready) begin
                  shift    <= tx_data;
                  // Parity is taken from the whole byte now, since shift is consumed bit by bit
                  par_bit  <= (PARITY == 2) ? ~(^tx_data) : ^tx_data;
                  clk_cnt  <= '0;
                  bit_idx  <= '0;
                  tx       <= 1'b0;
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  tx      <= shift[0];
                  state   <= S_DATA;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     if (PARITY != 0) begin
                        tx    <= par_bit;
                        state <= S_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  tx      <= 1'b1;
                  state   <= S_STOP;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  // bit_idx is reused to count stop bits
                  if (bit_idx == 3'(STOP_BITS - 1)) begin
                     bit_idx  <= '0;
                     tx_done  <= 1'b1;
                     tx_busy  <= 1'b0;
                     tx_ready <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (defaults, odd/2-stop, even/2-stop, 5 clocks/bit)
// checked cycle by cycle against a per-frame waveform model.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_valid [4];
   logic [7:0] tx_data  [4];
   logic       tx_s     [4];
   logic       ready    [4];
   logic       busy     [4];
   logic       done     [4];

   int cpb_c  [4] = '{16, 16, 16, 5};
   int stop_c [4] = '{1, 2, 2, 1};
   int par_c  [4] = '{0, 2, 1, 0};

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int start_cyc, done_cyc;
   bit exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx dut0 (.clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
                 .tx_ready(ready[0]), .tx(tx_s[0]), .tx_busy(busy[0]), .tx_done(done[0]));
   uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(2), .PARITY(2)) dut1 (.clk(clk), .reset(reset),
                 .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(ready[1]),
                 .tx(tx_s[1]), .tx_busy(busy[1]), .tx_done(done[1]));
   uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(2), .PARITY(1)) dut2 (.clk(clk), .reset(reset),
                 .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(ready[2]),
                 .tx(tx_s[2]), .tx_busy(busy[2]), .tx_done(done[2]));
   uart_tx #(.CLKS_PER_BIT(5), .STOP_BITS(1), .PARITY(0)) dut3 (.clk(clk), .reset(reset),
                 .tx_data(tx_data[3]), .tx_valid(tx_valid[3]), .tx_ready(ready[3]),
                 .tx(tx_s[3]), .tx_busy(busy[3]), .tx_done(done[3]));

   function automatic int frame_len(input int u);
      return (1 + 8 + ((par_c[u] != 0) ? 1 : 0) + stop_c[u]) * cpb_c[u];
   endfunction

   // Expected line level for each cycle from acceptance to the tx_done cycle
   function automatic void build(input int u, input logic [7:0] d);
      bit lvl [$];
      exp_q.delete();
      lvl.push_back(1'b0);
      for (int b = 0; b < 8; b++) lvl.push_back(d[b]);
      if (par_c[u] != 0) lvl.push_back(($countones(d) % 2 == 1) ^ (par_c[u] == 2));
      for (int s = 0; s < stop_c[u]; s++) lvl.push_back(1'b1);
      foreach (lvl[j])
         for (int c = 0; c < cpb_c[u]; c++) exp_q.push_back(lvl[j]);
      exp_q.push_back(1'b1);
   endfunction

   // Called just after a negedge with instance u idle; acceptance happens on the next posedge.
   task automatic check_frame(input int u, input logic [7:0] d, input bit keep_valid,
                              input logic [7:0] next_d, input string name);
      int f;
      logic [2:0] expv, got;
      f = frame_len(u);
      vectors++;
      if (ready[u] !== 1'b1) begin
         miscompares++;
         $display("FAIL %s ready_before: got %b want 1", name, ready[u]);
      end
      tx_valid[u] = 1'b1;
      tx_data[u]  = d;
      build(u, d);
      for (int i = 0; i <= f; i++) begin
         @(negedge clk);
         if (i == 0) start_cyc = cyc;
         if (i == f) done_cyc = cyc;
         if (keep_valid) begin
            if (i == 0) tx_data[u] = next_d;
         end else if (i < f) begin
            tx_valid[u] = 1'($urandom_range(0, 1));
            tx_data[u]  = 8'($urandom);
         end else begin
            tx_valid[u] = 1'b0;
         end
         expv = {exp_q[i], (i == f), (i < f)};
         got  = {tx_s[u], done[u], busy[u]};
         vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("FAIL %s cycle %0d {tx,done,busy}: got %b want %b", name, i, got, expv);
         end
      end
      if (!keep_valid) begin
         @(negedge clk);
         vectors++;
         if ({tx_s[u], done[u], busy[u], ready[u]} !== 4'b1001) begin
            miscompares++;
            $display("FAIL %s idle_after {tx,done,busy,ready}: got %b want 1001", name,
                     {tx_s[u], done[u], busy[u], ready[u]});
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #98;
      for (int u = 0; u < 4; u++) begin
         vectors++;
         if ({tx_s[u], ready[u], busy[u], done[u]} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_state[%0d] {tx,ready,busy,done}: got %b want 1000", u,
                     {tx_s[u], ready[u], busy[u], done[u]});
         end
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (50) begin
         @(negedge clk);
         for (int u = 0; u < 4; u++) begin
            vectors++;
            if ({tx_s[u], ready[u], busy[u], done[u]} !== 4'b1100) begin
               miscompares++;
               $display("FAIL idle[%0d] {tx,ready,busy,done}: got %b want 1100", u,
                        {tx_s[u], ready[u], busy[u], done[u]});
            end
         end
      end
   endtask

   task automatic test_single();
      check_frame(0, 8'hA5, 1'b0, 8'h00, "single_a5");
   endtask

   task automatic test_back_to_back();
      int s0, d0;
      check_frame(0, 8'h00, 1'b1, 8'hFF, "b2b_first");
      s0 = start_cyc;
      d0 = done_cyc;
      check_frame(0, 8'hFF, 1'b0, 8'h00, "b2b_second");
      vectors++;
      if (start_cyc - s0 !== frame_len(0) + 1) begin
         miscompares++;
         $display("FAIL b2b_start_pitch: got %0d want %0d", start_cyc - s0, frame_len(0) + 1);
      end
      vectors++;
      if (done_cyc - d0 !== frame_len(0) + 1) begin
         miscompares++;
         $display("FAIL b2b_done_pitch: got %0d want %0d", done_cyc - d0, frame_len(0) + 1);
      end
   endtask

   task automatic test_parity();
      check_frame(1, 8'h07, 1'b0, 8'h00, "odd_par_07");
      check_frame(2, 8'h07, 1'b0, 8'h00, "even_par_07");
   endtask

   task automatic test_timing();
      check_frame(3, 8'h81, 1'b0, 8'h00, "cpb5_81");
   endtask

   task automatic test_reset_mid_frame();
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'h3C;
      @(negedge clk);
      tx_valid[0] = 1'b0;
      repeat (16 * 4 + 5) @(negedge clk);
      vectors++;
      if ({tx_s[0], busy[0]} !== 2'b11) begin
         miscompares++;
         $display("FAIL mid_bit3 {tx,busy}: got %b want 11", {tx_s[0], busy[0]});
      end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if ({tx_s[0], busy[0], done[0], ready[0]} !== 4'b1000) begin
         miscompares++;
         $display("FAIL async_reset {tx,busy,done,ready}: got %b want 1000",
                  {tx_s[0], busy[0], done[0], ready[0]});
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({tx_s[0], busy[0], done[0], ready[0]} !== 4'b1001) begin
         miscompares++;
         $display("FAIL after_release {tx,busy,done,ready}: got %b want 1001",
                  {tx_s[0], busy[0], done[0], ready[0]});
      end
      check_frame(0, 8'h55, 1'b0, 8'h00, "post_reset_55");
   endtask

   task automatic test_random();
      for (int u = 0; u < 4; u++)
         for (int n = 0; n < 3; n++)
            check_frame(u, 8'($urandom), 1'b0, 8'h00, $sformatf("random_u%0d_n%0d", u, n));
   endtask

   initial begin
      for (int u = 0; u < 4; u++) begin
         tx_valid[u] = 1'b0;
         tx_data[u]  = 8'h00;
      end
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_timing();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter.
- Sits directly upstream of uart_rx: its `tx` output drives the `rx` line that uart_rx samples.
- Accepts parallel bytes on a valid/ready handshake and serialises each as a frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Default bit timing of 16 clocks per bit (160 ns at the 10 ns clock) matches the uart_rx default.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd. Default 0 matches uart_rx.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset: reset=0 resets the block immediately; deassertion is synchronous to clk.
- tx_data  input  8  byte to transmit; sampled only on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idle high. Registered, glitch-free.
- tx_busy  output  1  high while a frame is in progress (any state except IDLE).
- tx_done  output  1  one-cycle pulse when a frame has completed.

Behaviour:
- Reset values (reset=0): tx=1, tx_ready=0, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, clock counter=0, shift register=0.
- tx_ready rises on the first clk edge after reset deasserts.
- Reset mid-frame: tx returns high immediately (asynchronously); the partial frame is abandoned and never resumed.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - tx=1, tx_ready=1, tx_busy=0.
  - On an edge with tx_valid=1 and tx_ready=1 (acceptance, edge k): latch tx_data into the shift register, clear counters, set tx=0, tx_ready=0, tx_busy=1, go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA and drive bit 0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first; a 3-bit index counts 0..7.
  - After bit 7, go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - Even mode: tx = XOR of the latched byte.
  - Odd mode: tx = inverse of that XOR.
  - Held CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame end:
  - On the edge ending STOP: go to IDLE, set tx_done=1 (for one cycle only), tx_busy=0, tx_ready=1.
  - tx_done and tx_ready are high together in that cycle.
- Frame length: F = (1 + 8 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, measured from edge k to the edge where tx_done rises. Default F = 160.
- Back-to-back frames: with tx_valid held high, the next acceptance is the edge after tx_done rises. Frame pitch = F+1 cycles (exactly one idle-high cycle between frames). Default pitch = 161.
- Input stability: tx_data and tx_valid are ignored while busy. Changing tx_data mid-frame does not alter the frame in flight.
- Handshake: tx_valid may drop without acceptance; no byte is queued.
- Clock counter: width $clog2(CLKS_PER_BIT), compared against CLKS_PER_BIT-1. No wrap artefacts at power-of-two values.
- Data bits are fixed at 8. No flow control and no break generation.

Test Plan:
- Reset and idle:
  - Hold reset=0 for 100 ns, release, leave tx_valid=0 for 500 ns.
  - Required: tx=1 throughout, tx_ready=1 from the first edge after release, tx_busy=0, tx_done=0.
- Single frame, 0xA5, defaults:
  - Pulse tx_valid for 1 cycle.
  - Required: tx low for 160 ns, then 1,0,1,0,0,1,0,1 at 160 ns each, then high 160 ns.
  - tx_done is a one-cycle pulse 160 cycles after acceptance.
  - With tx looped into uart_rx: data_out=A5, rx_done=1.
- Back-to-back:
  - Hold tx_valid=1 with tx_data 0x00 then 0xFF, changing tx_data after the first acceptance.
  - Required: second start bit falls exactly 161 cycles after the first.
  - tx_data changes during the first frame have no effect on it.
  - tx_done pulses twice, 161 cycles apart.
- Parity and stop bits:
  - PARITY=2, STOP_BITS=2, send 0x07.
  - Required: parity bit = 0 (odd parity, three ones); stop high for 32 cycles; F = 192.
  - Repeat with PARITY=1: parity bit = 1.
- Reset mid-frame:
  - Assert reset=0 during data bit 3 of 0x3C.
  - Required: tx=1 immediately, with no clock edge needed; tx_busy=0, no tx_done.
  - After release, sending 0x55 produces a clean frame.
- Non-default timing:
  - CLKS_PER_BIT=5, send 0x81.
  - Required: each bit lasts 5 cycles; F = 50; tx_done 50 cycles after acceptance.
